// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops show-ahead bytes and packs PACK of them
// into one wide word on a valid/ready stream; a flush emits a masked partial word.
module fifo_rd_packer #(
   parameter int DATAWIDTH = 8,
   parameter int PACK      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATAWIDTH-1:0]      I_fifo_data,
   input  logic                      I_fifo_empty,
   output logic                      O_fifo_rden,
   input  logic                      I_flush,
   output logic [DATAWIDTH*PACK-1:0] O_data,
   output logic [PACK-1:0]           O_keep,
   output logic                      O_valid,
   input  logic                      I_ready,
   output logic                      O_dbg_state
);

   localparam int LW = $clog2(PACK);
   localparam int CW = LW + 1;
   localparam logic [CW-1:0] C_PACK = CW'(PACK);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   // Stream handshake: a word moves to the sink on any edge where O_valid & I_ready;
   // O_valid never drops and O_data/O_keep never change until that happens.
   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [PACK-1:0][DATAWIDTH-1:0] r_asm;
   logic [CW-1:0]                 r_cnt;
   logic [DATAWIDTH*PACK-1:0]     r_data;
   logic [PACK-1:0]               r_keep;
   logic                          r_valid;

   logic                          w_out_free;
   logic                          w_full;
   logic                          w_xfer;
   logic                          w_pop;
   logic [LW-1:0]                 w_lane;
   logic [DATAWIDTH*PACK-1:0]     w_data;
   logic [PACK-1:0]               w_keep;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:   if (I_flush) w_state_nxt = ST_FLUSH;
         ST_FLUSH: if (w_xfer || (r_cnt == '0)) w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   // A pop on a transfer cycle refills lane 0 so streaming never stalls.
   always_comb begin
      w_out_free = !r_valid || I_ready;
      w_full     = (r_cnt == C_PACK);
      w_xfer     = w_out_free && (w_full || ((r_state == ST_FLUSH) && (r_cnt != '0)));
      w_pop      = rst_n && !I_fifo_empty && (r_state == ST_RUN) && (!w_full || w_xfer);
      w_lane     = w_xfer ? '0 : r_cnt[LW-1:0];
   end

   always_comb begin
      w_data = '0;
      w_keep = '0;
      for (int i = 0; i < PACK; i++) begin
         w_keep[i] = (CW'(i) < r_cnt);
         if (w_keep[i]) w_data[i*DATAWIDTH +: DATAWIDTH] = r_asm[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_asm <= '0;
         r_cnt <= '0;
      end else begin
         if (w_pop) r_asm[w_lane] <= I_fifo_data;
         if (w_xfer)     r_cnt <= w_pop ? CW'(1) : '0;
         else if (w_pop) r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_keep  <= '0;
         r_valid <= 1'b0;
      end else if (w_xfer) begin
         r_data  <= w_data;
         r_keep  <= w_keep;
         r_valid <= 1'b1;
      end else if (I_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign O_fifo_rden = w_pop;
   assign O_data      = r_data;
   assign O_keep      = r_keep;
   assign O_valid     = r_valid;
   assign O_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO model feeds the DUT and a byte-stream
// model predicts every emitted word; directed cases plus a randomized soak.
module tb_fifo_rd_packer;

   localparam int W  = 8;
   localparam int P  = 4;
   localparam int EW = W*P + P;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [W-1:0]   fifo_data;
   logic           fifo_empty;
   logic           fifo_rden;
   logic           flush;
   logic [W*P-1:0] out_data;
   logic [P-1:0]   out_keep;
   logic           out_valid;
   logic           ready;
   logic           dbg_state;

   always #5 clk = ~clk;

   fifo_rd_packer #(.DATAWIDTH(W), .PACK(P)) dut (
      .clk(clk), .rst_n(rst_n),
      .I_fifo_data(fifo_data), .I_fifo_empty(fifo_empty), .O_fifo_rden(fifo_rden),
      .I_flush(flush), .O_data(out_data), .O_keep(out_keep), .O_valid(out_valid),
      .I_ready(ready), .O_dbg_state(dbg_state)
   );

   logic [W-1:0]  fifo_q[$];
   logic [W-1:0]  pend_q[$];
   logic [EW-1:0] exp_q[$];
   int n_cmp = 0, n_bad = 0;
   int cyc = 0, n_pops, n_words, n_valid_cyc, first_pop, last_pop, first_valid;
   int last_acc_cyc, max_gap, popped_total, acc_bytes, busy_age;
   bit busy, hold_chk, last_rden;
   logic [W*P-1:0] hold_data;
   logic [P-1:0]   hold_keep;
   logic [EW-1:0]  last_acc;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void refresh();
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = fifo_empty ? W'($urandom) : fifo_q[0];
   endfunction

   function automatic void push_word();
      logic [W*P-1:0] d;
      logic [P-1:0]   k;
      d = '0;
      k = '0;
      for (int i = 0; i < P; i++) begin
         if (pend_q.size() > 0) begin
            d[i*W +: W] = pend_q.pop_front();
            k[i] = 1'b1;
         end
      end
      exp_q.push_back({k, d});
   endfunction

   function automatic void mark();
      n_pops = 0; n_words = 0; n_valid_cyc = 0;
      first_pop = -1; last_pop = -1; first_valid = -1;
      last_acc_cyc = -1; max_gap = 0;
   endfunction

   // One clock: observe at negedge, update the model, then advance the FIFO after the edge.
   task automatic cycle();
      bit pop, acc;
      logic [EW-1:0] e;
      @(negedge clk);
      cyc++;
      pop = fifo_rden;
      acc = out_valid && ready;
      last_rden = pop;
      if (out_valid) begin
         n_valid_cyc++;
         if (first_valid < 0) first_valid = cyc;
      end
      if (hold_chk) begin
         check_eq("hold_valid", 64'(out_valid), 64'(1));
         check_eq("hold_data", 64'(out_data), 64'(hold_data));
         check_eq("hold_keep", 64'(out_keep), 64'(hold_keep));
      end
      hold_chk  = out_valid && !ready;
      hold_data = out_data;
      hold_keep = out_keep;
      if (acc) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_word", 64'({out_keep, out_data}), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check_eq("word", 64'({out_keep, out_data}), 64'(e));
         end
         last_acc = {out_keep, out_data};
         acc_bytes += $countones(out_keep);
         n_words++;
         if (last_acc_cyc >= 0 && cyc - last_acc_cyc > max_gap) max_gap = cyc - last_acc_cyc;
         last_acc_cyc = cyc;
      end
      if (pop) begin
         check_eq("pop_nonempty", 64'(fifo_q.size() > 0), 64'(1));
         if (fifo_q.size() > 0) pend_q.push_back(fifo_q[0]);
         popped_total++;
         n_pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
         if (pend_q.size() == P) push_word();
         check_eq("backlog", 64'(popped_total - acc_bytes <= 2*P), 64'(1));
      end
      if (flush && !busy) begin
         busy = 1;
         busy_age = 0;
         if (pend_q.size() > 0) push_word();
      end else if (busy) begin
         busy_age++;
         if (exp_q.size() == 0) busy = 0;
      end
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      refresh();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      fifo_q.delete(); pend_q.delete(); exp_q.delete();
      busy = 0; hold_chk = 0; popped_total = 0; acc_bytes = 0;
      flush = 1'b0;
      fifo_empty = 1'b0;
      fifo_data = 8'hEE;
      repeat (n) begin
         @(negedge clk);
         check_eq("rst_rden", 64'(fifo_rden), 64'(0));
         check_eq("rst_valid", 64'(out_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      refresh();
      @(negedge clk);
      check_eq("rel_valid", 64'(out_valid), 64'(0));
      check_eq("rel_data", 64'(out_data), 64'(0));
      check_eq("rel_keep", 64'(out_keep), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input int target, input int budget, input string tag);
      int k;
      k = 0;
      while (n_words < target && k < budget) begin
         cycle();
         k++;
      end
      check_eq(tag, 64'(n_words >= target), 64'(1));
   endtask

   task automatic drain(input string tag);
      int k;
      ready = 1'b1;
      flush = 1'b0;
      k = 0;
      while ((fifo_q.size() > 0 || busy) && k < 300) begin cycle(); k++; end
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      k = 0;
      while ((exp_q.size() > 0 || busy) && k < 300) begin cycle(); k++; end
      check_eq(tag, 64'(exp_q.size() == 0 && !busy), 64'(1));
   endtask

   initial begin
      logic [W-1:0] b[P];
      int fl_cyc;
      ready = 1'b0;
      flush = 1'b0;
      do_reset(3);

      // streaming
      ready = 1'b1;
      mark();
      fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      refresh();
      run_until(1, 20, "stream_timeout");
      check_eq("stream_pops", 64'(n_pops), 64'(4));
      check_eq("stream_consec", 64'(last_pop - first_pop), 64'(3));
      check_eq("stream_latency", 64'(first_valid - first_pop), 64'(P + 1));
      check_eq("stream_word", 64'(last_acc), 64'(36'hF_44332211));

      // backpressure
      ready = 1'b0;
      repeat (3) cycle();
      mark();
      for (int i = 1; i <= 12; i++) fifo_q.push_back(W'(i));
      refresh();
      repeat (20) cycle();
      check_eq("bp_pops", 64'(n_pops), 64'(8));
      check_eq("bp_rden", 64'(last_rden), 64'(0));
      check_eq("bp_valid", 64'(out_valid), 64'(1));
      check_eq("bp_data", 64'(out_data), 64'(32'h04030201));
      ready = 1'b1;
      mark();
      run_until(3, 40, "bp_timeout");
      check_eq("bp_gap", 64'(max_gap <= P), 64'(1));
      check_eq("bp_last", 64'(last_acc), 64'(36'hF_0C0B0A09));

      // partial flush
      mark();
      fifo_q = '{8'hA1, 8'hB2, 8'hC3};
      refresh();
      repeat (6) cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      run_until(1, 10, "pf_timeout");
      check_eq("pf_word", 64'(last_acc), 64'(36'h7_00C3B2A1));
      cycle();
      check_eq("pf_run", 64'(dbg_state), 64'(0));

      // flush with nothing assembled
      repeat (2) cycle();
      mark();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      repeat (6) cycle();
      check_eq("f0_novalid", 64'(n_valid_cyc), 64'(0));

      // flush together with the second pop
      mark();
      fifo_q = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
      refresh();
      cycle();
      flush = 1'b1;
      cycle();
      fl_cyc = cyc;
      flush = 1'b0;
      first_pop = -1;
      first_valid = -1;
      run_until(1, 10, "f2_timeout");
      check_eq("f2_word", 64'(last_acc), 64'(36'h3_00006655));
      check_eq("f2_valid_at", 64'(first_valid - fl_cyc), 64'(2));
      check_eq("f2_resume_at", 64'(first_pop - fl_cyc), 64'(2));
      drain("f2_drain");

      // randomized soak
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 3) != 0 && fifo_q.size() < 16) fifo_q.push_back(W'($urandom));
         ready = ($urandom_range(0, 3) != 0);
         flush = !busy && ($urandom_range(0, 30) == 0);
         refresh();
         cycle();
      end
      drain("rand_drain");

      // reset in the middle of a word
      ready = 1'b0;
      for (int i = 0; i < 6; i++) fifo_q.push_back(W'(8'hF0 + i));
      refresh();
      repeat (12) cycle();
      check_eq("mid_pre_valid", 64'(out_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_async_valid", 64'(out_valid), 64'(0));
      do_reset(2);
      ready = 1'b1;
      mark();
      for (int i = 0; i < P; i++) begin
         b[i] = W'($urandom);
         fifo_q.push_back(b[i]);
      end
      refresh();
      run_until(1, 20, "mid_timeout");
      check_eq("mid_word", 64'(last_acc), 64'({4'hF, b[3], b[2], b[1], b[0]}));
      check_eq("end_scoreboard", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the team's async FIFO, in the FIFO's read clock domain. It pops bytes from the FIFO's show-ahead read port (head data plus empty flag plus pop strobe) and packs PACK consecutive bytes into one wide word. Words go out on a valid/ready stream. A flush command emits a trailing partial word with a lane-valid mask, so upstream packet tails are never stranded in the assembly register.

## Interface
- DATAWIDTH, 8, width of one FIFO entry (one lane).
- PACK, 4, lanes per output word; ≥2, power of two.
- clk  in  1  single clock; the FIFO read clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- I_fifo_data  in  DATAWIDTH  FIFO head entry; valid whenever I_fifo_empty=0.
- I_fifo_empty  in  1  FIFO empty flag, registered in the FIFO.
- O_fifo_rden  out  1  pop strobe. One entry is consumed per cycle it is high.
- I_flush  in  1  single-cycle request to emit the partial word.
- O_data  out  DATAWIDTH*PACK  packed word. The first-popped byte is in bits [DATAWIDTH-1:0].
- O_keep  out  PACK  lane-valid mask. Bit i=1 means lane i holds data.
- O_valid  out  1  O_data/O_keep valid.
- I_ready  in  1  sink accepts the word. Transfer occurs when O_valid & I_ready.

## Operation
- **Storage:**
  - Assembly register `asm`, PACK lanes.
  - Lane count `cnt`, range 0..PACK, width clog2(PACK)+1.
  - Output register (O_data/O_keep/O_valid).
  - State bit: RUN or FLUSH.
- **out_free** = !O_valid | I_ready.
- **Transfer** (asm → output register, at clock edge):
  - Condition: out_free & ((cnt==PACK) | (state==FLUSH & cnt>0)).
  - O_keep takes the low cnt bits set; all ones for a full word.
  - Unfilled lanes of O_data are driven 0.
  - cnt returns to 0, or to 1 if a pop occurs in the same cycle.
- **Pop:**
  - O_fifo_rden = rst_n & !I_fifo_empty & state==RUN & (cnt<PACK | transfer).
  - The popped byte is written into lane cnt, or lane 0 on a transfer cycle.
  - O_fifo_rden is combinational from registered state, I_fifo_empty and I_ready.
- **State machine:**
  - RUN → FLUSH when I_flush=1. A byte popped in that same cycle belongs to the partial word.
  - FLUSH → RUN on the cycle a transfer occurs, or immediately if cnt==0 (nothing to emit, no O_valid).
  - I_flush is ignored while in FLUSH.
  - No pops occur in FLUSH.
- **Output register:** on O_valid & I_ready with no new transfer, O_valid→0. O_data/O_keep hold their values until the next transfer.
- **Wrap-around:** cnt never exceeds PACK. With asm full and the output stalled, pops stop; no byte is lost or overwritten.

## Timing
- Reset values (async, while rst_n=0):
  - O_valid=0, O_data=0, O_keep=0, O_fifo_rden=0.
  - cnt=0, asm=0, state=RUN.
- Latency: first pop in cycle t → O_valid high from cycle t+PACK+1, with I_ready=1 and the FIFO non-empty throughout.
- Throughput: sustained one pop per cycle, i.e. one word per PACK cycles, with I_ready=1.
- O_valid stays high and O_data/O_keep stay stable until I_ready is sampled high.
- Backpressure: with I_ready=0, at most 2*PACK bytes are popped beyond the last accepted word.
- Flush latency: partial word valid one cycle after the FLUSH cycle in which out_free=1.
- Reset mid-operation: all state is discarded immediately. Bytes already popped are lost; no pop occurs during reset.

## Test plan
- **Reset:**
  - Stimulus: hold rst_n=0 for 3 cycles with I_fifo_empty=0, then release with I_fifo_empty=1.
  - Required: O_fifo_rden=0 throughout reset; O_valid=0, O_data=0, O_keep=0 after release.
- **Streaming:**
  - Stimulus: FIFO holds 0x11,0x22,0x33,0x44; I_ready=1.
  - Required: O_fifo_rden high for 4 consecutive cycles; then one O_valid cycle with O_data=0x44332211, O_keep=4'b1111.
- **Backpressure:**
  - Stimulus: FIFO holds 0x01..0x0C; I_ready=0.
  - Required: exactly 8 pops occur, then O_fifo_rden=0 with O_data=0x04030201 held.
  - Then raise I_ready: words 0x04030201, 0x08070605, 0x0C0B0A09 appear in order with no gap larger than PACK cycles.
- **Partial flush:**
  - Stimulus: pop 0xA1,0xB2,0xC3, FIFO then empty, pulse I_flush.
  - Required: O_data=0x00C3B2A1, O_keep=4'b0111, after which the block is back in RUN.
- **Flush edge cases:**
  - Stimulus: pulse I_flush with cnt=0. Required: no O_valid.
  - Stimulus: pulse I_flush in the same cycle as the 2nd pop, with 0x55,0x66 queued and more data in the FIFO. Required: O_data=0x00006655, O_keep=4'b0011; pops resume only after that word transfers.
- **Reset mid-word:**
  - Stimulus: assert rst_n=0 while O_valid=1 and cnt=2.
  - Required: O_valid drops immediately, without waiting for a clock. After release, the next full word contains only post-reset bytes.
